output_accum_wb: RTL

//  Read-modify-write accumulator directly upstream of the dual-port output memory.

---
 rtl/output_accum_wb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/output_accum_wb.sv
// rtl/output_accum_wb.sv - read-modify-write tile accumulator in front of the dual-port output memory
//
// Takes a pair of partial-sum tiles (one per memory port), loads the stored
// tiles, adds the new tiles lane-wise and writes the sums back. A pair flagged
// first is written straight through without a load. One pair in flight at a time.
//
// Build option: OUT_ACC_SAT_EN - lane adds saturate to the signed LW-bit range;
//               when undefined, lane adds wrap modulo 2^LW.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         tile-pair handshake
//   in_first                    overwrite the stored tiles, skip the load
//   in_v1, in_v2                port 1 / port 2 member present
//   in_addr_1/2, in_data_1/2    target address and partial-sum tile per port
//   mem_addr_1/2                memory address per port (0 when port unused)
//   mem_pkg_1_vld/mem_pkg_2_vld port enables toward the memory
//   mem_rd_req, mem_wr_req      single-cycle load / write strobes
//   mem_wdata_1/2               write data per port (0 when port unused)
//   mem_rdata_1/2, mem_rd_valid load data return, any latency >= 1 cycle
//   busy                        a pair is being processed
//   tile_cnt                    tiles written since reset, wrapping
module output_accum_wb #(
  parameter int LANES = 32,
  parameter int LW    = 16,
  parameter int AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_v1,
  input  logic                  in_v2,
  input  logic [AW-1:0]         in_addr_1,
  input  logic [AW-1:0]         in_addr_2,
  input  logic [LANES*LW-1:0]   in_data_1,
  input  logic [LANES*LW-1:0]   in_data_2,
  output logic [AW-1:0]         mem_addr_1,
  output logic [AW-1:0]         mem_addr_2,
  output logic                  mem_pkg_1_vld,
  output logic                  mem_pkg_2_vld,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [LANES*LW-1:0]   mem_wdata_1,
  output logic [LANES*LW-1:0]   mem_wdata_2,
  input  logic [LANES*LW-1:0]   mem_rdata_1,
  input  logic [LANES*LW-1:0]   mem_rdata_2,
  input  logic                  mem_rd_valid,
  output logic                  busy,
  output logic [15:0]           tile_cnt
);

  localparam int DW = LANES * LW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Lane-wise add with no carry between lanes. The sum is formed one bit
  // wider than a lane so overflow is visible for the saturating build.
  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW-1:0] r;
`ifdef OUT_ACC_SAT_EN
    logic [LW:0] s;
`endif
    r = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef OUT_ACC_SAT_EN
      s = {a[i*LW+LW-1], a[i*LW +: LW]} + {b[i*LW+LW-1], b[i*LW +: LW]};
      // Top two bits disagree only when the signed result left the lane range.
      if (s[LW] != s[LW-1])
        r[i*LW +: LW] = s[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
      else
        r[i*LW +: LW] = s[LW-1:0];
`else
      r[i*LW +: LW] = a[i*LW +: LW] + b[i*LW +: LW];
`endif
    end
    return r;
  endfunction

  state_t          state_q;
  logic [AW-1:0]   addr1_q, addr2_q;
  logic            pkg1_q, pkg2_q;
  logic            rd_req_q, wr_req_q;
  logic [DW-1:0]   data1_q, data2_q;
  logic [DW-1:0]   wdata1_q, wdata2_q;
  logic [15:0]     tile_cnt_q;

  // Both members aimed at one address: fold port 2 into port 1 so the
  // memory never sees two writes to the same word in one cycle.
  logic            hazard_d;
  logic            v2_d;
  logic [DW-1:0]   data1_d;

  assign hazard_d = in_v1 & in_v2 & (in_addr_1 == in_addr_2);
  assign v2_d     = in_v2 & ~hazard_d;
  assign data1_d  = hazard_d ? lane_add(in_data_1, in_data_2) : in_data_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr1_q    <= '0;
      addr2_q    <= '0;
      pkg1_q     <= 1'b0;
      pkg2_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      data1_q    <= '0;
      data2_q    <= '0;
      wdata1_q   <= '0;
      wdata2_q   <= '0;
      tile_cnt_q <= '0;
    end else begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A pair with neither member present is accepted and dropped.
          if (in_valid && (in_v1 || in_v2)) begin
            pkg1_q  <= in_v1;
            pkg2_q  <= v2_d;
            addr1_q <= in_v1 ? in_addr_1 : '0;
            addr2_q <= v2_d ? in_addr_2 : '0;
            data1_q <= in_v1 ? data1_d : '0;
            data2_q <= v2_d ? in_data_2 : '0;
            if (in_first) begin
              state_q  <= S_WRITE;
              wr_req_q <= 1'b1;
              wdata1_q <= in_v1 ? data1_d : '0;
              wdata2_q <= v2_d ? in_data_2 : '0;
            end else begin
              state_q  <= S_LOAD;
              rd_req_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            state_q  <= S_WRITE;
            wr_req_q <= 1'b1;
            wdata1_q <= pkg1_q ? lane_add(mem_rdata_1, data1_q) : '0;
            wdata2_q <= pkg2_q ? lane_add(mem_rdata_2, data2_q) : '0;
          end
        end
        S_WRITE: begin
          state_q    <= S_IDLE;
          tile_cnt_q <= tile_cnt_q + {15'd0, pkg1_q} + {15'd0, pkg2_q};
          pkg1_q     <= 1'b0;
          pkg2_q     <= 1'b0;
          addr1_q    <= '0;
          addr2_q    <= '0;
          wdata1_q   <= '0;
          wdata2_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mem_addr_1    = addr1_q;
  assign mem_addr_2    = addr2_q;
  assign mem_pkg_1_vld = pkg1_q;
  assign mem_pkg_2_vld = pkg2_q;
  assign mem_rd_req    = rd_req_q;
  assign mem_wr_req    = wr_req_q;
  assign mem_wdata_1   = wdata1_q;
  assign mem_wdata_2   = wdata2_q;
  assign tile_cnt      = tile_cnt_q;

endmodule
